// File: rtl/fix_pkg.sv
// Shared types and constants for the FIX framing stage.
//   state_e  : framer FSM states
//   SOH, CH_*: byte constants used by the header/trailer matcher
//   is_digit : true for ASCII '0'..'9'
package fix_pkg;

  typedef enum logic [3:0] {
    IDLE, HDR, BODY, T1, T10, CK0, CK1, CK2, CKEND, DROP
  } state_e;

  localparam logic [7:0] SOH   = 8'h01;
  localparam logic [7:0] CH_8  = 8'h38;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_0  = 8'h30;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/fix_cks_acc.sv
// FIX checksum accumulator.
//   byte_i     : stream byte
//   accept_i   : byte belongs to the current (candidate) message
//   clear_i    : byte is the header '8'; restart the sum and the trailer value
//   snapshot_i : byte is a body SOH; latch the running sum including it
//   digit_i    : byte is a checksum digit; fold it into the decimal value
//   cks_ok_o   : trailer value fits a byte and equals the latched sum
module fix_cks_acc
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       accept_i,
  input  logic       clear_i,
  input  logic       snapshot_i,
  input  logic       digit_i,
  output logic       cks_ok_o
);

  logic [7:0] sum_q, snap_q, sum_nxt;
  logic [9:0] val_q;

  assign sum_nxt  = clear_i ? byte_i : sum_q + byte_i;
  assign cks_ok_o = (val_q[9:8] == 2'b00) && (val_q[7:0] == snap_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q  <= '0;
      snap_q <= '0;
      val_q  <= '0;
    end else if (accept_i) begin
      sum_q <= sum_nxt;
      if (snapshot_i) snap_q <= sum_nxt;
      // Digit bytes are '0'..'9', so the low nibble is the digit value.
      if (clear_i)      val_q <= '0;
      else if (digit_i) val_q <= val_q * 10'd10 + {6'd0, byte_i[3:0]};
    end
  end

endmodule

// File: rtl/fix_msg_framer.sv
// FIX message framer: hunts "8=", stores message bytes in the circular
// buffer, detects the "10=nnn<SOH>" trailer and reports start/end addresses.
//   data_i/valid_i : byte stream (always accepted)
//   full_i         : downstream location store full; new headers are dropped
//   wr_*_o         : buffer write port (registered, one cycle after accept)
//   start_*_o      : header accepted, address of the '8'
//   end_*_o        : message closed, address of the last stored byte
//   cks_err_o      : checksum mismatch or malformed trailer (with end pulse)
//   len_err_o      : length limit hit (with end pulse)
module fix_msg_framer
  import fix_pkg::*;
#(
  parameter int DATA_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  input  logic                  full_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_addr_o,
  output logic [7:0]            wr_data_o,
  output logic                  start_message_o,
  output logic [DATA_WIDTH-1:0] start_addr_o,
  output logic                  end_message_o,
  output logic [DATA_WIDTH-1:0] end_addr_o,
  output logic                  cks_err_o,
  output logic                  len_err_o
);

  localparam logic [DATA_WIDTH-1:0] LEN_LAST = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  state_e                state_q, state_d, body_st;
  logic                  drop_q, drop_d;   // parsing a message that is not stored
  logic                  fs_q, fs_d;       // next body byte starts a field
  logic [DATA_WIDTH-1:0] wr_ptr_q, ptr_d, len_q, len_d;
  logic in_msg, is_ck, body_byte, good_close, malformed, lim, close, cks_ok;

  // DROP marks a dropped message at field start; the trailer sub-states are
  // shared with stored messages and drop_q suppresses their outputs.
  assign body_st    = drop_q ? DROP : BODY;
  assign in_msg     = !(state_q inside {IDLE, HDR});
  assign is_ck      = state_q inside {CK0, CK1, CK2};
  assign good_close = valid_i && (state_q == CKEND) && (data_i == SOH);
  assign malformed  = valid_i && ((is_ck && !is_digit(data_i)) ||
                                  ((state_q == CKEND) && (data_i != SOH)));
  assign lim        = valid_i && in_msg && (len_q == LEN_LAST) && !good_close;
  assign close      = good_close || malformed || lim;
  // Byte handled as ordinary body content, including trailer-match misses.
  assign body_byte  = valid_i &&
    ((((state_q == BODY) || (state_q == DROP)) && !(fs_q && (data_i == CH_1))) ||
     ((state_q == T1)  && (data_i != CH_0)) ||
     ((state_q == T10) && (data_i != CH_EQ)));

  fix_cks_acc u_cks (
    .clk        (clk),
    .rst        (rst),
    .byte_i     (data_i),
    .accept_i   (valid_i && (in_msg || (state_q == HDR) || (data_i == CH_8))),
    .clear_i    (valid_i && !in_msg && (data_i == CH_8)),
    .snapshot_i (body_byte && (data_i == SOH)),
    .digit_i    (valid_i && is_ck && is_digit(data_i)),
    .cks_ok_o   (cks_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      fs_q     <= 1'b0;
      wr_ptr_q <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      fs_q     <= fs_d;
      wr_ptr_q <= ptr_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    fs_d    = fs_q;
    ptr_d   = wr_ptr_q;
    len_d   = len_q;
    if (valid_i) begin
      case (state_q)
        IDLE: if (data_i == CH_8) state_d = HDR;
        HDR: begin
          if (data_i == CH_EQ) begin
            fs_d   = 1'b1;
            len_d  = DATA_WIDTH'(2);
            drop_d = full_i;
            if (full_i) state_d = DROP;
            else begin
              state_d = BODY;
              ptr_d   = wr_ptr_q + DATA_WIDTH'(2);
            end
          end else if (data_i != CH_8) begin
            state_d = IDLE;
          end
        end
        default: begin
          len_d = len_q + 1'b1;
          if (!drop_q)  ptr_d = wr_ptr_q + 1'b1;
          if (body_byte) fs_d = (data_i == SOH);
          if (close) begin
            state_d = IDLE;
            drop_d  = 1'b0;
          end else begin
            case (state_q)
              T1:      state_d = (data_i == CH_0)  ? T10 : body_st;
              T10:     state_d = (data_i == CH_EQ) ? CK0 : body_st;
              CK0:     state_d = CK1;
              CK1:     state_d = CK2;
              CK2:     state_d = CKEND;
              default: state_d = (fs_q && (data_i == CH_1)) ? T1 : body_st;
            endcase
          end
        end
      endcase
    end
  end

  logic                  wr_en_d, start_d, end_d, cks_err_d, len_err_d;
  logic [DATA_WIDTH-1:0] wr_addr_d, start_addr_d, end_addr_d;
  logic [7:0]            wr_data_d;

  always_comb begin
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_o;
    wr_data_d    = wr_data_o;
    start_d      = 1'b0;
    start_addr_d = start_addr_o;
    end_d        = 1'b0;
    end_addr_d   = end_addr_o;
    cks_err_d    = 1'b0;
    len_err_d    = 1'b0;
    if (valid_i) begin
      case (state_q)
        IDLE, HDR: begin
          // '8' is written speculatively and overwritten if "=" never follows.
          if (data_i == CH_8) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = data_i;
          end else if ((state_q == HDR) && (data_i == CH_EQ) && !full_i) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = wr_ptr_q + 1'b1;
            wr_data_d    = data_i;
            start_d      = 1'b1;
            start_addr_d = wr_ptr_q;
          end
        end
        default: begin
          if (!drop_q) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = wr_ptr_q;
            wr_data_d  = data_i;
            end_d      = close;
            end_addr_d = wr_ptr_q;
            cks_err_d  = malformed || (good_close && !cks_ok);
            len_err_d  = lim;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_o         <= 1'b0;
      wr_addr_o       <= '0;
      wr_data_o       <= '0;
      start_message_o <= 1'b0;
      start_addr_o    <= '0;
      end_message_o   <= 1'b0;
      end_addr_o      <= '0;
      cks_err_o       <= 1'b0;
      len_err_o       <= 1'b0;
    end else begin
      wr_en_o         <= wr_en_d;
      wr_addr_o       <= wr_addr_d;
      wr_data_o       <= wr_data_d;
      start_message_o <= start_d;
      start_addr_o    <= start_addr_d;
      end_message_o   <= end_d;
      end_addr_o      <= end_addr_d;
      cks_err_o       <= cks_err_d;
      len_err_o       <= len_err_d;
    end
  end

endmodule

// File: tb/tb_fix_msg_framer.sv
// Self-checking bench for fix_msg_framer: directed scenarios plus random
// message streams, checked cycle by cycle against a queue-based model.
module tb_fix_msg_framer;

  localparam int DW = 5;
  localparam int DEPTH = 32;
  localparam logic [7:0] SOH = 8'h01;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    data_i = '0;
  logic          valid_i = 1'b0, full_i = 1'b0;
  logic          wr_en_o, start_message_o, end_message_o, cks_err_o, len_err_o;
  logic [DW-1:0] wr_addr_o, start_addr_o, end_addr_o;
  logic [7:0]    wr_data_o;

  fix_msg_framer #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .full_i(full_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .start_message_o(start_message_o), .start_addr_o(start_addr_o),
    .end_message_o(end_message_o), .end_addr_o(end_addr_o),
    .cks_err_o(cks_err_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: bytes of the current message kept in a queue ----
  logic [7:0] mq[$];
  int  m_ptr, m_ts;
  bit  m_hdr, m_in, m_drop;
  logic          e_wr_en, e_start, e_end, e_cks, e_len;
  logic [DW-1:0] e_wr_addr, e_start_addr, e_end_addr;
  logic [7:0]    e_wr_data;

  // observed-event capture
  int  n_start, n_end;
  bit  is_open;
  logic [DW-1:0] cap_start_addr, cap_end_addr;
  logic cap_cks, cap_len;

  task automatic model_reset();
    mq.delete();
    m_ptr = 0; m_ts = -1; m_hdr = 0; m_in = 0; m_drop = 0;
    is_open = 0; n_start = 0; n_end = 0;
  endtask

  task automatic model_step(input logic [7:0] b, input logic v, input logic f);
    int k, pos, val, snap;
    bit cl, ce, le, tc;
    e_wr_en = 0; e_start = 0; e_end = 0; e_cks = 0; e_len = 0;
    e_wr_addr = '0; e_start_addr = '0; e_end_addr = '0; e_wr_data = '0;
    if (!v) return;
    if (!m_in) begin
      if (m_hdr && b == 8'h3D) begin
        mq.push_back(b); m_in = 1; m_hdr = 0; m_ts = -1; m_drop = f;
        if (!f) begin
          e_wr_en = 1; e_wr_addr = DW'((m_ptr + 1) % DEPTH); e_wr_data = b;
          e_start = 1; e_start_addr = DW'(m_ptr);
          m_ptr = (m_ptr + 2) % DEPTH;
        end
      end else if (b == 8'h38) begin
        mq.delete(); mq.push_back(b); m_hdr = 1;
        e_wr_en = 1; e_wr_addr = DW'(m_ptr); e_wr_data = b;
      end else begin
        m_hdr = 0;
      end
      return;
    end
    k = mq.size();
    mq.push_back(b);
    cl = 0; ce = 0; le = 0; tc = 0;
    if (m_ts >= 0) begin
      pos = k - m_ts;                       // 3..5 digits, 6 final SOH
      if (pos < 6) begin
        if (!(b >= 8'h30 && b <= 8'h39)) begin cl = 1; ce = 1; end
      end else begin
        cl = 1;
        if (b != SOH) ce = 1;
        else begin
          tc = 1;
          val = (int'(mq[m_ts+3]) - 48) * 100 + (int'(mq[m_ts+4]) - 48) * 10 +
                (int'(mq[m_ts+5]) - 48);
          snap = 0;
          for (int i = 0; i < m_ts; i++) snap += int'(mq[i]);
          snap = snap % 256;
          ce = (val > 255) || ((val % 256) != snap);
        end
      end
    end else if (k >= 4 && mq[k-2] == 8'h31 && mq[k-1] == 8'h30 && b == 8'h3D &&
                 (k == 4 || mq[k-3] == SOH)) begin
      m_ts = k - 2;
    end
    if (mq.size() == DEPTH - 1 && !tc) begin cl = 1; le = 1; end
    if (!m_drop) begin
      e_wr_en = 1; e_wr_addr = DW'(m_ptr); e_wr_data = b;
      m_ptr = (m_ptr + 1) % DEPTH;
      if (cl) begin e_end = 1; e_end_addr = e_wr_addr; e_cks = ce; e_len = le; end
    end
    if (cl) begin m_in = 0; m_drop = 0; end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic v, input logic f);
    logic [27:0] obs, exp;
    data_i = b; valid_i = v; full_i = f;
    model_step(b, v, f);
    @(posedge clk); #1;
    obs = {wr_en_o, e_wr_en ? wr_addr_o : 5'd0, e_wr_en ? wr_data_o : 8'd0,
           start_message_o, e_start ? start_addr_o : 5'd0,
           end_message_o, e_end ? end_addr_o : 5'd0, cks_err_o, len_err_o};
    exp = {e_wr_en, e_wr_addr, e_wr_data, e_start, e_start_addr,
           e_end, e_end_addr, e_cks, e_len};
    chk("cycle", 32'(obs), 32'(exp));
    if (start_message_o) begin
      chk("alt_start", 32'(is_open), 32'd0);
      is_open = 1; n_start++; cap_start_addr = start_addr_o;
    end
    if (end_message_o) begin
      chk("alt_end", 32'(is_open), 32'd1);
      is_open = 0; n_end++;
      cap_end_addr = end_addr_o; cap_cks = cks_err_o; cap_len = len_err_o;
    end
  endtask

  // '|' stands for SOH; full_i is raised on byte index full_at.
  task automatic send_str(input string s, input int full_at = -1);
    logic [7:0] b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      if (b == "|") b = SOH;
      send_byte(b, 1'b1, i == full_at);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; valid_i = 1'b0; full_i = 1'b0;
    @(posedge clk); #1;
    chk("reset_outputs", 32'({wr_en_o, wr_addr_o, wr_data_o, start_message_o,
        start_addr_o, end_message_o, end_addr_o, cks_err_o, len_err_o}), 32'd0);
    rst = 1'b1;
    model_reset();
  endtask

  logic [7:0] rq[$];

  task automatic send_random_msg();
    logic [7:0] pool[8];
    logic [7:0] gar[3];
    int n, s, kind, val;
    pool = '{8'h41, 8'h42, 8'h31, 8'h30, 8'h3D, SOH, 8'h35, 8'h39};
    gar  = '{8'h58, 8'h38, 8'h3D};
    rq.delete();
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) rq.push_back(gar[$urandom_range(0, 2)]);
    rq.push_back(8'h38); rq.push_back(8'h3D); rq.push_back(8'h41);
    n = $urandom_range(0, 28);
    for (int i = 0; i < n; i++) rq.push_back(pool[$urandom_range(0, 7)]);
    rq.push_back(SOH);
    s = 0;
    for (int i = 0; i < rq.size(); i++)
      if (i >= rq.size() - n - 4) s += int'(rq[i]);   // bytes from the '8'
    s = s % 256;
    kind = $urandom_range(0, 4);
    val = (kind == 2) ? (s + 1) % 256 : (kind == 3) ? s + 256 : s;
    rq.push_back(8'h31); rq.push_back(8'h30); rq.push_back(8'h3D);
    rq.push_back(8'(48 + val / 100));
    rq.push_back((kind == 4) ? 8'h5A : 8'(48 + (val / 10) % 10));
    rq.push_back(8'(48 + val % 10));
    rq.push_back(SOH);
    for (int i = 0; i < rq.size(); i++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      send_byte(rq[i], 1'b1, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    model_reset();
    do_reset();

    // good message from reset
    send_str("8=A|10=183|");
    chk("good_nstart", n_start, 1);
    chk("good_start_addr", 32'(cap_start_addr), 0);
    chk("good_nend", n_end, 1);
    chk("good_end_addr", 32'(cap_end_addr), 10);
    chk("good_cks", 32'(cap_cks), 0);

    // bad checksum
    do_reset();
    send_str("8=A|10=184|");
    chk("badcks_end_addr", 32'(cap_end_addr), 10);
    chk("badcks_cks", 32'(cap_cks), 1);

    // false header
    do_reset();
    send_str("8X8=A|10=183|");
    chk("false_start_addr", 32'(cap_start_addr), 0);
    chk("false_end_addr", 32'(cap_end_addr), 10);

    // full at '=' drops the message; next one starts at 0
    do_reset();
    send_str("8=A|10=183|", 1);
    chk("full_no_pulse", n_start + n_end, 0);
    send_str("8=A|10=183|");
    chk("full_next_start", 32'(cap_start_addr), 0);
    chk("full_next_nend", n_end, 1);

    // length limit
    do_reset();
    send_str("8=BBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBBB");
    chk("len_nend", n_end, 1);
    chk("len_end_addr", 32'(cap_end_addr), 30);
    chk("len_err", 32'(cap_len), 1);

    // wrap and mid-message reset
    do_reset();
    send_str("8=A|10=183|8=A|10=183|8=A|10=183|");
    chk("wrap_nend", n_end, 3);
    chk("wrap_end_addr", 32'(cap_end_addr), 0);
    chk("wrap_cks", 32'(cap_cks), 0);
    send_str("8=A|10=");
    do_reset();
    send_str("8=A|10=183|");
    chk("after_reset_start", 32'(cap_start_addr), 0);
    chk("after_reset_end", 32'(cap_end_addr), 10);

    // random streams
    do_reset();
    for (int m = 0; m < 60; m++) send_random_msg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
